// File: rtl/dpcm_pkg.sv
// Shared DPCM types, saturation limits and the clamped predictor add.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable; used by both the encoder and the decoder.
package dpcm_pkg;

  localparam int DPCM_WIDTH = 8;

  typedef logic        [DPCM_WIDTH-1:0] sample_t;
  typedef logic signed [DPCM_WIDTH-1:0] diff_t;

  localparam sample_t SAMPLE_MIN = 8'd0;
  localparam sample_t SAMPLE_MAX = 8'd255;

  typedef struct packed {
    sample_t value;
    logic    clamped;
  } clampResult_t;

  // prev + diff evaluated two bits wider than a sample, so both the negative
  // (bit 9 set) and the above-255 (bit 8 set) cases are visible without
  // wrapping: the reachable range is -128..382.
  function automatic clampResult_t clamp_add(sample_t prev, diff_t diff);
    logic [DPCM_WIDTH+1:0] sum;
    clampResult_t          res;
    sum = {2'b00, prev} + {{2{diff[DPCM_WIDTH-1]}}, diff};
    if (sum[DPCM_WIDTH+1]) begin
      res.value   = SAMPLE_MIN;
      res.clamped = 1'b1;
    end else if (sum[DPCM_WIDTH]) begin
      res.value   = SAMPLE_MAX;
      res.clamped = 1'b1;
    end else begin
      res.value   = sum[DPCM_WIDTH-1:0];
      res.clamped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dpcm_fifo.sv
// Small synchronous FIFO holding decoded samples; head is always presented.
// Latency: a push at edge N is visible at head after N when the FIFO was empty.
// Backpressure: push ignored when full, pop ignored when empty; no pass-through.
module dpcm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (doPush && !doPop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (!doPush && doPop) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/dpcm_decoder.sv
// DPCM decoder: running clamped predictor feeding a valid/ready output FIFO.
// Latency: accept at edge N appears on DataOut after N (FIFO empty); 1/cycle.
// Backpressure: Ready drops only when the FIFO is full, from registered state.
// Optional: define DPCM_DEC_CLAMP_CNT_EN to add the 16-bit ClampCount port.
module dpcm_decoder
  import dpcm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid,
  output logic             Ready,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Restart,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] DataOut
`ifdef DPCM_DEC_CLAMP_CNT_EN
  ,
  output logic [15:0]      ClampCount
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = FIFO_DEPTH[CNT_W-1:0];

  sample_t          predictor;
  sample_t          base;
  clampResult_t     decoded;
  logic             accept;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;

  assign Ready    = !fifoFull;
  assign OutValid = !fifoEmpty;
  assign accept   = Valid && Ready;

  // A Restart in the same cycle as an accept decodes that sample against 0.
  assign base    = Restart ? SAMPLE_MIN : predictor;
  assign decoded = clamp_add(base, diff_t'(DataIn));

  // Predictor tracks the last decoded sample; Restart alone zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      predictor <= SAMPLE_MIN;
    end else if (accept) begin
      predictor <= decoded.value;
    end else if (Restart) begin
      predictor <= SAMPLE_MIN;
    end
  end

  dpcm_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .pushData (decoded.value),
    .pop      (OutValid && OutReady),
    .head     (DataOut),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // The FIFO flags must always agree with its level.
  assert property (@(posedge clk) disable iff (rst)
    (fifoFull == (fifoCount == FULL_CNT)) && (fifoEmpty == (fifoCount == '0)));

`ifdef DPCM_DEC_CLAMP_CNT_EN
  // Saturating count of accepted samples that hit either clamp limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ClampCount <= '0;
    end else if (accept && decoded.clamped && (ClampCount != 16'hFFFF)) begin
      ClampCount <= ClampCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dpcm_decoder.sv
// Directed bench for dpcm_decoder: vector table plus multi-cycle sequences.
// Latency: inputs change 1 time unit after a rising edge, outputs checked there.
// Backpressure: exercised through OutReady stalls and a full FIFO.
module tb_dpcm_decoder;

  logic       clk;
  logic       rst;
  logic       Valid;
  logic       Ready;
  logic [7:0] DataIn;
  logic       Restart;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] DataOut;
`ifdef DPCM_DEC_CLAMP_CNT_EN
  logic [15:0] ClampCount;
`endif

  int compared;
  int mismatched;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rs;
    logic       ordy;
    logic       expV;
    logic [7:0] expD;
    logic       expR;
  } vec_t;

  vec_t vecs [16];

  dpcm_decoder #(
    .WIDTH      (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Valid    (Valid),
    .Ready    (Ready),
    .DataIn   (DataIn),
    .Restart  (Restart),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .DataOut  (DataOut)
`ifdef DPCM_DEC_CLAMP_CNT_EN
    ,
    .ClampCount (ClampCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic v, input logic [7:0] d, input logic rs, input logic ordy);
    Valid    = v;
    DataIn   = d;
    Restart  = rs;
    OutReady = ordy;
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOut(input string name, input logic expV, input logic [7:0] expD,
                          input logic expR);
    check({name, ".OutValid"}, int'(OutValid), int'(expV));
    check({name, ".Ready"}, int'(Ready), int'(expR));
    if (expV) check({name, ".DataOut"}, int'(DataOut), int'(expD));
  endtask

  // One cycle: apply inputs, take the edge, compare outputs.
  task automatic step(input string name, input logic v, input logic [7:0] d, input logic rs,
                      input logic ordy, input logic expV, input logic [7:0] expD,
                      input logic expR);
    setIn(v, d, rs, ordy);
    tick();
    checkOut(name, expV, expD, expR);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // v, diff, restart, outReady | expected OutValid, DataOut, Ready
    vecs[0]  = '{1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 8'd10,  1'b1};
    vecs[1]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'd15,  1'b1};
    vecs[2]  = '{1'b1, 8'hFD, 1'b0, 1'b1, 1'b1, 8'd12,  1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1};
    vecs[4]  = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 8'd139, 1'b1};
    vecs[5]  = '{1'b1, 8'h6F, 1'b0, 1'b1, 1'b1, 8'd250, 1'b1};
    vecs[6]  = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1};
    vecs[7]  = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 8'd127, 1'b1};
    vecs[8]  = '{1'b1, 8'h86, 1'b0, 1'b1, 1'b1, 8'd5,   1'b1};
    vecs[9]  = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 8'd0,   1'b1};
    vecs[10] = '{1'b1, 8'h64, 1'b0, 1'b1, 1'b1, 8'd100, 1'b1};
    vecs[11] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'd7,   1'b1};
    vecs[12] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'd10,  1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1};
    vecs[14] = '{1'b1, 8'h09, 1'b0, 1'b1, 1'b1, 8'd9,   1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1};

    rst = 1'b1;
    setIn(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("reset.OutValid", int'(OutValid), 0);
    check("reset.Ready", int'(Ready), 1);
    check("reset.DataOut", int'(DataOut), 0);
`ifdef DPCM_DEC_CLAMP_CNT_EN
    check("reset.ClampCount", int'(ClampCount), 0);
`endif
    rst = 1'b0;

    // Stream, both clamps, Restart with and without a coincident sample.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].rs, vecs[i].ordy,
           vecs[i].expV, vecs[i].expD, vecs[i].expR);
    end
`ifdef DPCM_DEC_CLAMP_CNT_EN
    check("clampCount", int'(ClampCount), 2);
`endif

    // Back-pressure: zero predictor, fill the FIFO with a stalled consumer.
    step("bp.restart", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    step("bp.push1", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
    step("bp.push2", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
    step("bp.push3", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
    step("bp.push4", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
    step("bp.held", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
    step("bp.pop1", 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'd2, 1'b1);
    step("bp.push5", 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1);
    step("bp.pop3", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd4, 1'b1);
    step("bp.pop4", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd5, 1'b1);
    step("bp.drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);

    // Simultaneous push/pop at count 2 (predictor is 5).
    step("pp.push6", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd6, 1'b1);
    step("pp.push7", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd6, 1'b1);
    step("pp.both", 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'd7, 1'b1);
    step("pp.stall", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1);
    step("pp.pop7", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd8, 1'b1);
    step("pp.empty", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);

    // Reset mid-stream with three buffered samples (predictor is 8).
    step("mr.push9", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd9, 1'b1);
    step("mr.push10", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd9, 1'b1);
    step("mr.push11", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd9, 1'b1);
    rst = 1'b1;
    step("mr.reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("mr.reset.DataOut", int'(DataOut), 0);
`ifdef DPCM_DEC_CLAMP_CNT_EN
    check("mr.reset.ClampCount", int'(ClampCount), 0);
`endif
    rst = 1'b0;
    step("mr.diff20", 1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 8'd20, 1'b1);
    step("mr.empty", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
